// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder and the memory stage.
// State encoding and byte-enable width live here so both sides agree.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int BE_W = 4;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port RAM for the data-memory responder.
// Byte-enable writes, registered reads, no reset on the storage.
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [BE_W-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write or registered read, only when enabled.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: one access at a time,
// programmable wait states, misaligned/out-of-range error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (AW + 2);
        return (a[1:0] != 2'b00) || (hi != '0);
    endfunction

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             write_q;
    logic [AW-1:0]    idx_q;
    logic [31:0]      wdata_q;
    logic [BE_W-1:0]  be_q;
    logic             err_q;

    logic             idle;
    logic             accept;
    logic             enter_resp;

    logic             cur_write;
    logic [AW-1:0]    cur_idx;
    logic [31:0]      cur_wdata;
    logic [BE_W-1:0]  cur_be;
    logic             cur_err;

    logic [31:0]      ram_rdata;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle && reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states the RAM is touched on the accepting edge,
    // before the latches hold the request, so take fields live then.
    assign cur_write = idle ? req_write : write_q;
    assign cur_idx   = idle ? req_addr[AW+1:2] : idx_q;
    assign cur_wdata = idle ? req_wdata : wdata_q;
    assign cur_be    = idle ? req_be : be_q;
    assign cur_err   = idle ? addr_err(req_addr) : err_q;

    // Next-state logic; enter_resp marks the edge that performs the access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= addr_err(req_addr);
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clock),
        .en_i    (enter_resp && !cur_err),
        .we_i    (cur_write),
        .be_i    (cur_be),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? ram_rdata : '0;
    assign busy       = reset && (!idle || req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with a word-array reference model.
// Also exercises a zero-wait-state instance for latency and busy timing.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        r0_valid = 1'b0;
    logic        r0_ready;
    logic        r0_write = 1'b0;
    logic [31:0] r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic [3:0]  r0_be = '0;
    logic        s0_valid;
    logic        s0_ready = 1'b1;
    logic [31:0] s0_rdata;
    logic        s0_err;
    logic        busy0;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready),
        .req_write(r0_write), .req_addr(r0_addr),
        .req_wdata(r0_wdata), .req_be(r0_be),
        .resp_valid(s0_valid), .resp_ready(s0_ready),
        .resp_rdata(s0_rdata), .resp_err(s0_err),
        .busy(busy0)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_chk = 0;
    int          n_pass = 0;
    int          rr_mode = 0;
    bit          inflight = 0;
    bit          resp_open = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic note_fail(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: byte-addressed view of a word array.
    task automatic model(input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output exp_t e);
        int idx;
        e.err = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        e.rdata = '0;
        e.acc = cyc;
        if (!e.err) begin
            idx = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = mem_m[idx];
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b);
        exp_t e;
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_wdata = wd;
        req_be = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) note_fail("req_accept_timeout");
        else begin
            model(w, a, wd, b, e);
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        req_wdata = $urandom;
        req_be = 4'($urandom);
    endtask

    always @(posedge clock) begin
        #1;
        if (rr_mode == 0) resp_ready = 1'b1;
        else if (rr_mode == 1) resp_ready = ($urandom_range(0, 3) != 0);
        else resp_ready = 1'b0;
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            inflight = 0;
            resp_open = 0;
        end else begin
            chk("busy", 32'(busy), 32'(inflight || req_valid));
            if (resp_valid) begin
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (q.size() == 0) begin
                    note_fail("spurious_resp");
                end else begin
                    if (!resp_open) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(WAITC + 1));
                        resp_open = 1;
                    end
                    chk("rdata", resp_rdata, q[0].rdata);
                    chk("err", 32'(resp_err), 32'(q[0].err));
                    if (resp_ready) begin
                        void'(q.pop_front());
                        resp_open = 0;
                        inflight = 0;
                    end
                end
            end
            if (req_valid && req_ready) inflight = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clock);
        if (q.size() != 0) note_fail("drain_timeout");
        #1;
    endtask

    logic [31:0] ra;
    int          sel;

    initial begin
        repeat (3) @(negedge clock);
        chk_zero_outs("rst");
        req_valid = 1'b1;
        #1;
        chk_zero_outs("rst_reqv");
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;

        for (int i = 0; i < DEPTH; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b0, 32'h12, 32'h0, 4'h0);
        do_req(1'b1, 32'h400, 32'h55555555, 4'hF);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        do_req(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        drain();

        rr_mode = 2;
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        fork
            do_req(1'b0, 32'h0, 32'h0, 4'h0);
        join_none
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clock);
        repeat (5) begin
            @(negedge clock);
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_rdata_held", resp_rdata, 32'hDEADBEAA);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rr_mode = 0;
        wait fork;
        drain();

        rr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                ra = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1)
                ra = $urandom | 32'h0000_0400;
            else if (sel < 6)
                ra = {26'd0, 4'($urandom), 2'b00};
            else
                ra = {22'd0, 8'($urandom), 2'b00};
            do_req(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom));
        end
        drain();
        rr_mode = 0;
        @(posedge clock);
        #1;

        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'h12345678;
        req_be = 4'hF;
        @(negedge clock);
        chk("midrst_accept", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk_zero_outs("midrst");
        @(negedge clock);
        chk_zero_outs("midrst_hold");
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clock);
        @(posedge clock);
        #1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        drain();

        chk("w0_busy_idle", 32'(busy0), 32'd0);
        r0_valid = 1'b1;
        r0_write = 1'b1;
        r0_addr = 32'h8;
        r0_wdata = 32'hCAFEF00D;
        r0_be = 4'hF;
        #1;
        chk("w0_busy_same_cycle", 32'(busy0), 32'd1);
        @(negedge clock);
        chk("w0_ready", 32'(r0_ready), 32'd1);
        @(posedge clock);
        #1;
        r0_valid = 1'b0;
        @(negedge clock);
        chk("w0_st_valid", 32'(s0_valid), 32'd1);
        chk("w0_st_err", 32'(s0_err), 32'd0);
        chk("w0_st_rdata", s0_rdata, 32'd0);
        @(posedge clock);
        #1;
        r0_valid = 1'b1;
        r0_write = 1'b0;
        @(negedge clock);
        chk("w0_ready2", 32'(r0_ready), 32'd1);
        @(posedge clock);
        #1;
        r0_valid = 1'b0;
        @(negedge clock);
        chk("w0_ld_valid", 32'(s0_valid), 32'd1);
        chk("w0_ld_rdata", s0_rdata, 32'hCAFEF00D);
        @(posedge clock);
        #1;
        r0_valid = 1'b1;
        r0_addr = 32'h6;
        @(negedge clock);
        @(posedge clock);
        #1;
        r0_valid = 1'b0;
        @(negedge clock);
        chk("w0_err", 32'(s0_err), 32'd1);
        chk("w0_err_rdata", s0_rdata, 32'd0);
        @(negedge clock);
        chk("w0_idle_after", 32'(s0_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
